// File: rtl/sram_pkg.sv
// sram_pkg: constants shared by the external SRAM bus controller
// and the on-chip SRAM responder.
package sram_pkg;

    // Bus widths used by both the control unit and the responder.
    localparam int SRAM_ADDR_W = 17;
    localparam int SRAM_DATA_W = 32;

    // Read latencies that still meet the controller's sample points.
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 3;

    // Responder read state machine encoding.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DRIVE = 2'd2;

    function automatic logic lat_legal(input int lat);
        return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
    endfunction

endpackage

// File: rtl/sram_responder_array.sv
// sram_array: DEPTH x DATA_W storage with synchronous write and
// a registered read port. Contents are never cleared by reset.
module sram_array
    import sram_pkg::*;
#(
    parameter int DEPTH  = 2048,
    parameter int DATA_W = SRAM_DATA_W,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Commit write data on every enabled edge; the last edge wins.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    // Capture the addressed word into the read register on request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_ridx];
        end
    end

endmodule

// File: rtl/sram_responder.sv
// sram_responder: device side of the external SRAM bus. Serves
// reads after a fixed latency, commits writes per edge, counts both.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int DATA_W   = SRAM_DATA_W,
    parameter int DEPTH    = 2048,
    parameter int READ_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_WE_N,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int         IDX_W      = $clog2(DEPTH);
    localparam logic [1:0] LAT_RELOAD = 2'(READ_LAT - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr_q;
    logic [1:0]        r_lat_cnt;
    logic [CNT_W-1:0]  r_rd_count;
    logic [CNT_W-1:0]  r_wr_count;

    logic [1:0]        w_state_nx;
    logic              w_reload;
    logic              w_load;
    logic              w_dec;
    logic              w_wr;
    logic              w_hit;
    logic              w_oe;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rd_q;

    // Upper address bits are ignored, so addresses alias modulo DEPTH.
    assign w_idx = SRAM_ADDR[IDX_W-1:0];
    assign w_wr  = ~SRAM_CE_N & ~SRAM_WE_N;
    assign w_hit = (SRAM_ADDR == r_addr_q);

    // Drive only while the captured read still matches the bus, so an
    // address change or a write request releases DQ in the same cycle.
    assign w_oe     = (r_state == DRIVE) & ~SRAM_CE_N & SRAM_WE_N & w_hit;
    assign SRAM_DQ  = w_oe ? w_rd_q : {DATA_W{1'bz}};
    assign rd_valid = w_oe;
    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;

    // Next-state logic: writes and deselect drop back to IDLE, reads
    // count down the latency and restart whenever the address moves.
    always_comb begin
        w_state_nx = r_state;
        w_reload   = 1'b0;
        w_load     = 1'b0;
        w_dec      = 1'b0;
        if (SRAM_CE_N || !SRAM_WE_N) begin
            w_state_nx = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_reload = 1'b1;
                    if (READ_LAT == 1) begin
                        w_load     = 1'b1;
                        w_state_nx = DRIVE;
                    end else begin
                        w_state_nx = WAIT;
                    end
                end
                WAIT: begin
                    if (!w_hit) begin
                        w_reload = 1'b1;
                    end else if (r_lat_cnt == 2'd1) begin
                        w_load     = 1'b1;
                        w_state_nx = DRIVE;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                DRIVE: begin
                    if (!w_hit) begin
                        w_reload = 1'b1;
                        if (READ_LAT == 1) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nx = WAIT;
                        end
                    end
                end
                default: w_state_nx = IDLE;
            endcase
        end
    end

    // State, captured address, latency counter and saturating counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_addr_q   <= '0;
            r_lat_cnt  <= 2'd0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_reload) begin
                r_addr_q  <= SRAM_ADDR;
                r_lat_cnt <= LAT_RELOAD;
            end else if (w_dec) begin
                r_lat_cnt <= r_lat_cnt - 2'd1;
            end
            if (w_load && !(&r_rd_count)) begin
                r_rd_count <= r_rd_count + CNT_W'(1);
            end
            if (w_wr && !(&r_wr_count)) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
        end
    end

    // The array is read at the edge entering DRIVE, so a read right
    // after a write to the same word returns the new data.
    sram_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst),
        .i_we    (w_wr),
        .i_widx  (w_idx),
        .i_wdata (SRAM_DQ),
        .i_re    (w_load),
        .i_ridx  (w_idx),
        .o_rdata (w_rd_q)
    );

    a_we_known: assert property (
        @(posedge clk) disable iff (!rst)
        !SRAM_CE_N |-> !$isunknown(SRAM_WE_N)
    ) else $error("SRAM_WE_N unknown while SRAM_CE_N is low");

    a_lat_legal: assert property (
        @(posedge clk) lat_legal(READ_LAT)
    ) else $error("READ_LAT outside supported range");

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed bench driving three responders
// (READ_LAT 1/2/3) from one controller-style stimulus stream.
module tb_sram_responder;

    logic        clk;
    logic        rst;
    logic        ce_n;
    logic        we_n;
    logic [16:0] addr;
    logic        tb_drv;
    logic [31:0] tb_wdata;

    wire  [31:0] dq1, dq2, dq3;
    logic        rdv1, rdv2, rdv3;
    logic [2:0]  rdc1, wrc1;
    logic [15:0] rdc2, wrc2, rdc3, wrc3;

    int checks = 0;
    int errors = 0;

    assign dq1 = tb_drv ? tb_wdata : 32'bz;
    assign dq2 = tb_drv ? tb_wdata : 32'bz;
    assign dq3 = tb_drv ? tb_wdata : 32'bz;

    sram_responder #(.READ_LAT(1), .CNT_W(3)) u_l1 (
        .clk(clk), .rst(rst), .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n),
        .SRAM_ADDR(addr), .SRAM_DQ(dq1), .rd_valid(rdv1),
        .rd_count(rdc1), .wr_count(wrc1)
    );

    sram_responder #(.READ_LAT(2)) u_l2 (
        .clk(clk), .rst(rst), .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n),
        .SRAM_ADDR(addr), .SRAM_DQ(dq2), .rd_valid(rdv2),
        .rd_count(rdc2), .wr_count(wrc2)
    );

    sram_responder #(.READ_LAT(3)) u_l3 (
        .clk(clk), .rst(rst), .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n),
        .SRAM_ADDR(addr), .SRAM_DQ(dq3), .rd_valid(rdv3),
        .rd_count(rdc3), .wr_count(wrc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        ce_n   = 1'b1;
        we_n   = 1'b1;
        tb_drv = 1'b0;
    endtask

    task automatic rd_issue(input logic [16:0] a);
        ce_n   = 1'b0;
        we_n   = 1'b1;
        tb_drv = 1'b0;
        addr   = a;
    endtask

    task automatic write_word(input logic [16:0] a, input logic [31:0] d,
                              input int n);
        ce_n     = 1'b0;
        we_n     = 1'b0;
        tb_drv   = 1'b1;
        addr     = a;
        tb_wdata = d;
        repeat (n) step();
    endtask

    task automatic do_reset;
        bus_idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset;
        rst = 1'b0;
        addr = '0;
        tb_wdata = '0;
        bus_idle();
        step();
        step();
        #4;
        checks++; if (rdv2 !== 1'b0) begin errors++; $display("FAIL rst_rdv: got %b exp 0", rdv2); end
        checks++; if (rdc2 !== 16'd0) begin errors++; $display("FAIL rst_rdc: got %0d exp 0", rdc2); end
        checks++; if (wrc2 !== 16'd0) begin errors++; $display("FAIL rst_wrc: got %0d exp 0", wrc2); end
        step();
        rst = 1'b1;
        step();
        write_word(17'h00010, 32'hDEADBEEF, 1);
        write_word(17'h00041, 32'hCAFEF00D, 1);
        rd_issue(17'h00010);
        step();
        step();
        #4;
        checks++; if (rdv2 !== 1'b1) begin errors++; $display("FAIL pre_rst_rdv: got %b exp 1", rdv2); end
        checks++; if (dq2 !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_rst_dq: got %h exp deadbeef", dq2); end
        rst = 1'b0;
        #1;
        checks++; if (rdv2 !== 1'b0) begin errors++; $display("FAIL midrd_rst_rdv: got %b exp 0", rdv2); end
        checks++; if (rdc2 !== 16'd0) begin errors++; $display("FAIL midrd_rst_rdc: got %0d exp 0", rdc2); end
        checks++; if (wrc2 !== 16'd0) begin errors++; $display("FAIL midrd_rst_wrc: got %0d exp 0", wrc2); end
        step();
        bus_idle();
        step();
        rst = 1'b1;
        step();
        rd_issue(17'h00010);
        step();
        step();
        #4;
        checks++; if (rdv2 !== 1'b1) begin errors++; $display("FAIL post_rst_rdv: got %b exp 1", rdv2); end
        checks++; if (dq2 !== 32'hDEADBEEF) begin errors++; $display("FAIL post_rst_dq: got %h exp deadbeef", dq2); end
        step();
        bus_idle();
        step();
    endtask

    task automatic test_write_read;
        do_reset();
        write_word(17'h00040, 32'h12345678, 6);
        bus_idle();
        #4;
        checks++; if (wrc2 !== 16'd6) begin errors++; $display("FAIL wr_count6: got %0d exp 6", wrc2); end
        step();
        rd_issue(17'h00040);
        #4;
        checks++; if (rdv2 !== 1'b0) begin errors++; $display("FAIL ctl_c0_rdv: got %b exp 0", rdv2); end
        step();
        step();
        #4;
        checks++; if (rdv2 !== 1'b1) begin errors++; $display("FAIL ctl_c2_rdv: got %b exp 1", rdv2); end
        checks++; if (dq2 !== 32'h12345678) begin errors++; $display("FAIL ctl_c2_dq: got %h exp 12345678", dq2); end
        step();
        addr = 17'h00041;
        #4;
        checks++; if (rdv2 !== 1'b0) begin errors++; $display("FAIL ctl_c3_rdv: got %b exp 0", rdv2); end
        step();
        step();
        #4;
        checks++; if (rdv2 !== 1'b1) begin errors++; $display("FAIL ctl_c5_rdv: got %b exp 1", rdv2); end
        checks++; if (dq2 !== 32'hCAFEF00D) begin errors++; $display("FAIL ctl_c5_dq: got %h exp cafef00d", dq2); end
        step();
        bus_idle();
        step();
        #4;
        checks++; if (rdc2 !== 16'd2) begin errors++; $display("FAIL rd_count2: got %0d exp 2", rdc2); end
        step();
    endtask

    task automatic test_latency_sweep;
        logic ev1, ev2, ev3;
        bus_idle();
        step();
        rd_issue(17'h00010);
        for (int k = 0; k < 4; k++) begin
            ev1 = (k >= 1);
            ev2 = (k >= 2);
            ev3 = (k >= 3);
            #4;
            checks++; if (rdv1 !== ev1) begin errors++; $display("FAIL lat1_c%0d: got %b exp %b", k, rdv1, ev1); end
            checks++; if (rdv2 !== ev2) begin errors++; $display("FAIL lat2_c%0d: got %b exp %b", k, rdv2, ev2); end
            checks++; if (rdv3 !== ev3) begin errors++; $display("FAIL lat3_c%0d: got %b exp %b", k, rdv3, ev3); end
            step();
        end
        #4;
        checks++; if (dq1 !== 32'hDEADBEEF) begin errors++; $display("FAIL lat1_dq: got %h exp deadbeef", dq1); end
        checks++; if (dq3 !== 32'hDEADBEEF) begin errors++; $display("FAIL lat3_dq: got %h exp deadbeef", dq3); end
        step();
        bus_idle();
        step();
    endtask

    task automatic test_addr_change;
        logic ev;
        write_word(17'h00008, 32'h08080808, 1);
        write_word(17'h00009, 32'h09090909, 1);
        bus_idle();
        step();
        rd_issue(17'h00008);
        #4;
        checks++; if (rdv3 !== 1'b0) begin errors++; $display("FAIL chg_c0: got %b exp 0", rdv3); end
        step();
        addr = 17'h00009;
        for (int k = 1; k <= 4; k++) begin
            ev = (k == 4);
            #4;
            checks++; if (rdv3 !== ev) begin errors++; $display("FAIL chg_c%0d: got %b exp %b", k, rdv3, ev); end
            step();
        end
        #4;
        checks++; if (dq3 !== 32'h09090909) begin errors++; $display("FAIL chg_dq: got %h exp 09090909", dq3); end
        step();
        bus_idle();
        step();
    endtask

    task automatic test_turnaround;
        write_word(17'h00020, 32'h11111111, 1);
        bus_idle();
        step();
        rd_issue(17'h00020);
        step();
        step();
        #4;
        checks++; if (dq2 !== 32'h11111111) begin errors++; $display("FAIL ta_rd_dq: got %h exp 11111111", dq2); end
        step();
        we_n     = 1'b0;
        tb_drv   = 1'b1;
        tb_wdata = 32'h22222222;
        #4;
        checks++; if (rdv2 !== 1'b0) begin errors++; $display("FAIL ta_oe: got %b exp 0", rdv2); end
        checks++; if (dq2 !== 32'h22222222) begin errors++; $display("FAIL ta_bus: got %h exp 22222222", dq2); end
        step();
        we_n   = 1'b1;
        tb_drv = 1'b0;
        step();
        step();
        #4;
        checks++; if (rdv2 !== 1'b1) begin errors++; $display("FAIL raw_rdv: got %b exp 1", rdv2); end
        checks++; if (dq2 !== 32'h22222222) begin errors++; $display("FAIL raw_dq: got %h exp 22222222", dq2); end
        step();
        bus_idle();
        step();
    endtask

    task automatic test_alias_sat;
        write_word(17'h00800, 32'hA5A5A5A5, 1);
        rd_issue(17'h00000);
        step();
        step();
        #4;
        checks++; if (rdv2 !== 1'b1) begin errors++; $display("FAIL alias_rdv: got %b exp 1", rdv2); end
        checks++; if (dq2 !== 32'hA5A5A5A5) begin errors++; $display("FAIL alias_dq: got %h exp a5a5a5a5", dq2); end
        step();
        do_reset();
        write_word(17'h00030, 32'h00000000, 9);
        bus_idle();
        #4;
        checks++; if (wrc1 !== 3'd7) begin errors++; $display("FAIL wr_sat: got %0d exp 7", wrc1); end
        checks++; if (wrc2 !== 16'd9) begin errors++; $display("FAIL wr_nosat: got %0d exp 9", wrc2); end
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_latency_sweep();
        test_addr_change();
        test_turnaround();
        test_alias_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
